// File: rtl/mem_rr_arbiter_if.sv
// Bundle of requester-side and memory-side signals for mem_rr_arbiter.
// The arbiter connects through the slave modport; traffic sources and the
// memory model connect through the master modport.
interface mem_rr_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 16
);
    // requester side
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        we;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [DATA_W-1:0]         rdata;
    logic                      parity_err;
    logic [CNT_W-1:0]          err_cnt;
    logic                      busy;

    // memory side
    logic                      mem_write;
    logic                      mem_read;
    logic [ADDR_W-1:0]         mem_address;
    logic [DATA_W-1:0]         mem_data_in;
    logic [DATA_W:0]           mem_data_out;

    modport slave (
        input  req, we, addr, wdata, mem_data_out,
        output gnt, resp_valid, rdata, parity_err, err_cnt, busy,
        output mem_write, mem_read, mem_address, mem_data_in
    );

    modport master (
        output req, we, addr, wdata, mem_data_out,
        input  gnt, resp_valid, rdata, parity_err, err_cnt, busy,
        input  mem_write, mem_read, mem_address, mem_data_in
    );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port byte memory between NUM_REQ
// requesters. Each access takes three cycles (IDLE -> ACC -> RSP); reads
// are parity-checked and mismatches feed a saturating error counter.
module mem_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_rr_arbiter_if.slave bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [NUM_REQ-1:0] win_oh;
    logic               lat_we;

    logic [ADDR_W-1:0]  addr_a  [NUM_REQ];
    logic [DATA_W-1:0]  wdata_a [NUM_REQ];

    logic               pick_valid;
    logic [IDX_W-1:0]   pick;
    logic [NUM_REQ-1:0] pick_oh;
    logic [IDX_W:0]     cand;
    logic [IDX_W-1:0]   cidx;
    logic [IDX_W-1:0]   ptr_next;
    logic               rd_perr;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_a[i]  = bus.addr[i*ADDR_W +: ADDR_W];
        assign wdata_a[i] = bus.wdata[i*DATA_W +: DATA_W];
    end

    // First requesting index at or above the RR pointer, wrapping around.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        pick_oh    = '0;
        cand       = '0;
        cidx       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            cidx = cand[IDX_W-1:0];
            if (!pick_valid && bus.req[cidx]) begin
                pick_valid = 1'b1;
                pick       = cidx;
            end
        end
        pick_oh[pick] = pick_valid;
    end

    assign ptr_next = (pick == IDX_W'(NUM_REQ - 1)) ? '0 : pick + IDX_W'(1);

    // Even parity: stored parity bit must equal the XOR of the data bits.
    assign rd_perr = bus.mem_data_out[DATA_W] ^ (^bus.mem_data_out[DATA_W-1:0]);

    // Access sequencer: arbitration, memory strobes, response and error count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            ptr             <= '0;
            win_oh          <= '0;
            lat_we          <= 1'b0;
            bus.gnt         <= '0;
            bus.resp_valid  <= '0;
            bus.rdata       <= '0;
            bus.parity_err  <= 1'b0;
            bus.err_cnt     <= '0;
            bus.busy        <= 1'b0;
            bus.mem_write   <= 1'b0;
            bus.mem_read    <= 1'b0;
            bus.mem_address <= '0;
            bus.mem_data_in <= '0;
        end else begin
            // pulses last one cycle unless a state below re-asserts them
            bus.gnt        <= '0;
            bus.resp_valid <= '0;
            bus.mem_write  <= 1'b0;
            bus.mem_read   <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        bus.gnt         <= pick_oh;
                        win_oh          <= pick_oh;
                        lat_we          <= bus.we[pick];
                        bus.mem_write   <= bus.we[pick];
                        bus.mem_read    <= !bus.we[pick];
                        bus.mem_address <= addr_a[pick];
                        bus.mem_data_in <= wdata_a[pick];
                        ptr             <= ptr_next;
                        bus.busy        <= 1'b1;
                        state           <= ACC;
                    end
                end
                ACC: begin
                    state <= RSP;
                end
                RSP: begin
                    bus.resp_valid <= win_oh;
                    if (!lat_we) begin
                        bus.rdata      <= bus.mem_data_out[DATA_W-1:0];
                        bus.parity_err <= rd_perr;
                        if (rd_perr && (bus.err_cnt != '1)) begin
                            bus.err_cnt <= bus.err_cnt + CNT_W'(1);
                        end
                    end else begin
                        bus.parity_err <= 1'b0;
                    end
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: directed transaction table, multi-cycle corner
// sequences, randomized traffic against a transaction-level model, and
// counter saturation on a narrow-counter instance.
module tb_mem_rr_arbiter;
    localparam int NR = 2;
    localparam int AW = 16;
    localparam int DW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_rr_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .CNT_W(16)) bus ();
    mem_rr_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .CNT_W(2))  bus2 ();

    mem_rr_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    mem_rr_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .CNT_W(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    int total = 0;
    int bad   = 0;

    // memory model: stores {parity, data}; optional parity corruption on reads
    logic [DW:0] mem [int unsigned];
    logic [DW:0] rd_word;
    logic        flip_all = 1'b0;
    logic        flip_f   = 1'b0;

    // single-port memory answering one cycle after mem_read
    always @(posedge clk) begin
        if (bus.mem_write) begin
            mem[32'(bus.mem_address)] = {^bus.mem_data_in, bus.mem_data_in};
        end
        if (bus.mem_read) begin
            rd_word = mem.exists(32'(bus.mem_address)) ? mem[32'(bus.mem_address)] : '0;
            if (flip_all || (flip_f && bus.mem_address[3:0] == 4'hF)) begin
                rd_word[DW] = ~rd_word[DW];
            end
            bus.mem_data_out <= rd_word;
        end
    end

    // narrow-counter instance always sees corrupt data
    always @(posedge clk) begin
        if (bus2.mem_read) bus2.mem_data_out <= 9'h1A5;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic r, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req[i]           = r;
        bus.we[i]            = w;
        bus.addr[i*AW +: AW] = a;
        bus.wdata[i*DW +: DW] = d;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},   64'(bus.gnt), 0);
        chk({tag, "_resp"},  64'(bus.resp_valid), 0);
        chk({tag, "_rdata"}, 64'(bus.rdata), 0);
        chk({tag, "_perr"},  64'(bus.parity_err), 0);
        chk({tag, "_cnt"},   64'(bus.err_cnt), 0);
        chk({tag, "_busy"},  64'(bus.busy), 0);
        chk({tag, "_strb"},  64'({bus.mem_write, bus.mem_read}), 0);
        chk({tag, "_maddr"}, 64'(bus.mem_address), 0);
        chk({tag, "_mdin"},  64'(bus.mem_data_in), 0);
    endtask

    typedef struct {
        int unsigned rq;
        logic        we;
        logic [15:0] a;
        logic [7:0]  d;
        logic        flip;
        logic [7:0]  e_rdata;
        logic        e_perr;
        logic [15:0] e_cnt;
    } vec_t;

    typedef struct {
        logic [NR-1:0] oh;
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } gev_t;

    typedef struct {
        logic [NR-1:0] oh;
        logic [DW-1:0] rd;
        logic          perr;
        logic [15:0]   cnt;
    } rev_t;

    vec_t          vt [6];
    gev_t          gev [int];
    rev_t          rev [int];
    bit            bsy [int];
    logic [DW-1:0] mmem [int unsigned];

    bit            pend [NR];
    logic          dwe  [NR];
    logic [AW-1:0] da   [NR];
    logic [DW-1:0] dd   [NR];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NR-1:0] oh;
        int g_slot [6];
        int g_id   [6];
        int gc;
        int next_arb, m_ptr, m_cnt, w;
        logic [DW-1:0] m_rdata;
        logic [NR-1:0] cur_req;
        gev_t ge;
        rev_t re;

        vt[0] = '{0, 1'b1, 16'h1234, 8'hA5, 1'b0, 8'h00, 1'b0, 16'd0};
        vt[1] = '{1, 1'b0, 16'h1234, 8'h00, 1'b0, 8'hA5, 1'b0, 16'd0};
        vt[2] = '{0, 1'b1, 16'h0010, 8'h07, 1'b0, 8'hA5, 1'b0, 16'd0};
        vt[3] = '{1, 1'b0, 16'h0010, 8'h00, 1'b0, 8'h07, 1'b0, 16'd0};
        vt[4] = '{0, 1'b0, 16'h1234, 8'h00, 1'b1, 8'hA5, 1'b1, 16'd1};
        vt[5] = '{1, 1'b0, 16'h1234, 8'h00, 1'b1, 8'hA5, 1'b1, 16'd2};

        bus.req = '0;  bus.we = '0;  bus.addr = '0;  bus.wdata = '0;
        bus2.req = '0; bus2.we = '0; bus2.addr = '0; bus2.wdata = '0;

        // reset values
        tick();
        tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // directed transactions, fixed latency from an idle arbiter
        foreach (vt[v]) begin
            oh = '0;
            oh[vt[v].rq] = 1'b1;
            flip_all = vt[v].flip;
            set_req(int'(vt[v].rq), 1'b1, vt[v].we, vt[v].a, vt[v].d);
            tick();
            chk("tbl_gnt",   64'(bus.gnt), 64'(oh));
            chk("tbl_wr",    64'(bus.mem_write), 64'(vt[v].we));
            chk("tbl_rd",    64'(bus.mem_read), 64'(!vt[v].we));
            chk("tbl_maddr", 64'(bus.mem_address), 64'(vt[v].a));
            if (vt[v].we) chk("tbl_mdin", 64'(bus.mem_data_in), 64'(vt[v].d));
            chk("tbl_busy1", 64'(bus.busy), 1);
            bus.req = '0;
            tick();
            chk("tbl_gnt_off",  64'(bus.gnt), 0);
            chk("tbl_strb_off", 64'({bus.mem_write, bus.mem_read}), 0);
            chk("tbl_maddr_hold", 64'(bus.mem_address), 64'(vt[v].a));
            chk("tbl_busy2", 64'(bus.busy), 1);
            tick();
            chk("tbl_resp",  64'(bus.resp_valid), 64'(oh));
            chk("tbl_rdata", 64'(bus.rdata), 64'(vt[v].e_rdata));
            chk("tbl_perr",  64'(bus.parity_err), 64'(vt[v].e_perr));
            chk("tbl_cnt",   64'(bus.err_cnt), 64'(vt[v].e_cnt));
            chk("tbl_busy3", 64'(bus.busy), 0);
            tick();
            chk("tbl_resp_off", 64'(bus.resp_valid), 0);
        end
        flip_all = 1'b0;

        // reset during ACC of a read from requester 0
        set_req(0, 1'b1, 1'b0, 16'h0010, 8'h00);
        tick();
        chk("rst_pre_gnt", 64'(bus.gnt), 1);
        #1 rst_n = 1'b0;
        #1 chk_all_zero("rst_async");
        set_req(0, 1'b1, 1'b0, 16'h0010, 8'h00);
        set_req(1, 1'b1, 1'b0, 16'h0020, 8'h00);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_rel_resp1", 64'(bus.resp_valid), 0);
        chk("rst_rel_gnt",   64'(bus.gnt), 1);
        bus.req = '0;
        tick();
        chk("rst_rel_resp2", 64'(bus.resp_valid), 0);
        tick();
        chk("rst_rel_resp3", 64'(bus.resp_valid), 1);
        tick();

        // contention: both requesters reading continuously from reset
        rst_n = 1'b0;
        set_req(0, 1'b1, 1'b0, 16'h0100, 8'h00);
        set_req(1, 1'b1, 1'b0, 16'h0200, 8'h00);
        tick();
        tick();
        rst_n = 1'b1;
        gc = 0;
        for (int cyc = 0; cyc < 40 && gc < 6; cyc++) begin
            tick();
            chk("cont_excl", 64'(bus.mem_write & bus.mem_read), 0);
            if (bus.gnt != '0) begin
                g_id[gc]   = (bus.gnt == 2'b01) ? 0 : ((bus.gnt == 2'b10) ? 1 : 9);
                g_slot[gc] = cyc;
                gc++;
            end
        end
        chk("cont_count", 64'(gc), 6);
        for (int i = 0; i < gc; i++) begin
            chk("cont_order", 64'(g_id[i]), 64'(i % 2));
            if (i > 0) chk("cont_space", 64'(g_slot[i] - g_slot[i-1]), 3);
        end
        bus.req = '0;
        tick();
        tick();
        tick();

        // randomized traffic against a transaction-level model
        rst_n = 1'b0;
        bus.req = '0;
        flip_f = 1'b1;
        tick();
        rst_n = 1'b1;
        next_arb = 1;
        m_ptr    = 0;
        m_cnt    = 0;
        m_rdata  = '0;
        for (int i = 0; i < NR; i++) pend[i] = 1'b0;
        for (int n = 0; n < 300; n++) begin
            // compare this slot against scheduled expectations
            if (gev.exists(n)) begin
                chk("rnd_gnt",   64'(bus.gnt), 64'(gev[n].oh));
                chk("rnd_wr",    64'(bus.mem_write), 64'(gev[n].we));
                chk("rnd_rd",    64'(bus.mem_read), 64'(!gev[n].we));
                chk("rnd_maddr", 64'(bus.mem_address), 64'(gev[n].a));
                if (gev[n].we) chk("rnd_mdin", 64'(bus.mem_data_in), 64'(gev[n].d));
            end else begin
                chk("rnd_gnt0",  64'(bus.gnt), 0);
                chk("rnd_strb0", 64'({bus.mem_write, bus.mem_read}), 0);
            end
            if (rev.exists(n)) begin
                chk("rnd_resp",  64'(bus.resp_valid), 64'(rev[n].oh));
                chk("rnd_rdata", 64'(bus.rdata), 64'(rev[n].rd));
                chk("rnd_perr",  64'(bus.parity_err), 64'(rev[n].perr));
                chk("rnd_cnt",   64'(bus.err_cnt), 64'(rev[n].cnt));
            end else begin
                chk("rnd_resp0", 64'(bus.resp_valid), 0);
            end
            chk("rnd_busy", 64'(bus.busy), 64'(bsy.exists(n)));

            // requester drivers: hold until granted, occasionally withdraw
            for (int i = 0; i < NR; i++) begin
                if (gev.exists(n) && gev[n].oh[i]) begin
                    pend[i] = 1'b0;
                end else if (pend[i] && ($urandom % 16 == 0)) begin
                    pend[i] = 1'b0;
                end else if (!pend[i] && n < 290 && ($urandom % 3 == 0)) begin
                    pend[i] = 1'b1;
                    dwe[i]  = 1'($urandom % 2);
                    da[i]   = 16'h8000 | 16'($urandom % 48);
                    dd[i]   = 8'($urandom);
                end
                set_req(i, pend[i], dwe[i], da[i], dd[i]);
            end

            // model: arbitration opportunity at the next edge
            cur_req = '0;
            for (int i = 0; i < NR; i++) cur_req[i] = pend[i];
            if (n + 1 >= next_arb && cur_req != '0) begin
                w = -1;
                for (int k = 0; k < NR; k++) begin
                    int c;
                    c = (m_ptr + k) % NR;
                    if (w < 0 && cur_req[c]) w = c;
                end
                ge.oh = '0;
                ge.oh[w] = 1'b1;
                ge.we = dwe[w];
                ge.a  = da[w];
                ge.d  = dd[w];
                gev[n+1] = ge;
                bsy[n+1] = 1'b1;
                bsy[n+2] = 1'b1;
                re.oh = ge.oh;
                if (ge.we) begin
                    mmem[32'(ge.a)] = ge.d;
                    re.perr = 1'b0;
                end else begin
                    m_rdata = mmem.exists(32'(ge.a)) ? mmem[32'(ge.a)] : '0;
                    re.perr = (ge.a[3:0] == 4'hF);
                    if (re.perr && m_cnt < 65535) m_cnt++;
                end
                re.rd  = m_rdata;
                re.cnt = 16'(m_cnt);
                rev[n+3] = re;
                next_arb = n + 4;
                m_ptr = (w + 1) % NR;
            end
            tick();
        end
        bus.req = '0;
        flip_f = 1'b0;
        tick();
        tick();
        tick();

        // saturation of a 2-bit error counter
        for (int k = 1; k <= 5; k++) begin
            bus2.req  = 2'b01;
            bus2.we   = 2'b00;
            bus2.addr = 32'h0000_0040;
            tick();
            chk("sat_gnt", 64'(bus2.gnt), 1);
            bus2.req = '0;
            tick();
            tick();
            chk("sat_resp",  64'(bus2.resp_valid), 1);
            chk("sat_rdata", 64'(bus2.rdata), 64'h A5);
            chk("sat_perr",  64'(bus2.parity_err), 1);
            chk("sat_cnt",   64'(bus2.err_cnt), 64'((k < 3) ? k : 3));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
- Round-robin arbiter that shares one single-port byte memory (16-bit address, 8-bit write data, 9-bit read data carrying a parity bit) between NUM_REQ requesters.
- Sequences the memory read/write strobes and returns read data to the granted requester.
- Checks read parity and keeps a saturating parity-error count.
- Sits between the memory interface and the traffic sources (bench drivers now, DMA/CPU ports later).

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 16, memory address width.
- DATA_W, 8, data width; memory read word is DATA_W+1 bits, parity in MSB.
- CNT_W, 16, width of the parity-error counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  per-requester request, held until matching gnt.
- we  input  NUM_REQ  per-requester 1=write, 0=read; valid with req.
- addr  input  NUM_REQ*ADDR_W  packed per-requester address (requester i at [i*ADDR_W +: ADDR_W]).
- wdata  input  NUM_REQ*DATA_W  packed per-requester write data.
- gnt  output  NUM_REQ  one-hot grant, one-cycle pulse.
- resp_valid  output  NUM_REQ  one-hot completion pulse, one cycle.
- rdata  output  DATA_W  read data, valid with resp_valid.
- parity_err  output  1  read parity mismatch, valid with resp_valid.
- err_cnt  output  CNT_W  saturating count of parity errors.
- busy  output  1  high whenever state != IDLE.
- mem_write  output  1  memory write strobe.
- mem_read  output  1  memory read strobe.
- mem_address  output  ADDR_W  memory address.
- mem_data_in  output  DATA_W  memory write data.
- mem_data_out  input  DATA_W+1  memory read data {parity, data}, valid the cycle after mem_read.

Behaviour:
- Reset (async, rst_n=0): state IDLE; the following are 0:
  - gnt, resp_valid, rdata, parity_err, err_cnt, busy
  - mem_write, mem_read, mem_address, mem_data_in
  - RR pointer = 0, so requester 0 has first priority.
- Reset mid-transaction: the in-flight access is abandoned and no resp_valid is issued.
- All outputs are registered.
- FSM states: IDLE, ACC, RSP.
  - IDLE: if any req bit is set, select the first set bit searching upward from the RR pointer with wrap-around.
    - Latch the winner's we, addr and wdata.
    - Next cycle: gnt[winner]=1 and state=ACC.
    - Also next cycle: mem_write=we or mem_read=!we, with mem_address/mem_data_in driven from the latched values.
    - RR pointer <= winner+1 mod NUM_REQ.
    - No req: stay in IDLE with all strobes 0.
  - ACC (exactly 1 cycle): strobes high; next state RSP; gnt and strobes return to 0. mem_address/mem_data_in hold their values.
  - RSP (exactly 1 cycle): mem_data_out is valid. On exit, resp_valid[winner]=1.
    - Read: rdata <= mem_data_out[DATA_W-1:0]; parity_err <= mem_data_out[DATA_W] != ^mem_data_out[DATA_W-1:0] (even parity). err_cnt increments on error and saturates at all-ones.
    - Write: rdata unchanged, parity_err=0.
    - Next state IDLE.
- Timing: req seen in cycle T gives gnt and strobe in T+1, data sampled in T+2, resp_valid in T+3. IDLE samples req again in T+3, so the next gnt is at T+4 at the earliest (3-cycle throughput).
- req dropped before grant: no access occurs. After gnt, the requester may change its inputs freely.
- mem_write and mem_read are never high together; at most one gnt bit and one resp_valid bit are high.
- Only requests present while in IDLE are arbitrated. Requests arriving during ACC/RSP wait.

Test Plan:
- Single write then read: req0 writes 0x1234<-0xA5. Then req1 reads 0x1234 with the memory model returning 0x0A5.
  - Write: gnt[0] at T+1, mem_write=1 for 1 cycle, resp_valid[0] at T+3.
  - Read: rdata=0xA5, parity_err=0, err_cnt=0.
- Odd-parity data: write 0x0010<-0x07, read back with mem_data_out=0x107 -> rdata=0x07, parity_err=0.
- Parity injection: the memory model returns 0x1A5 for a read -> parity_err=1 with resp_valid, err_cnt=1. A second corrupt read gives err_cnt=2.
- Contention: req0 and req1 held continuously from reset, 6 reads.
  - Grants alternate 0,1,0,1,0,1; gnt pulses are spaced 3 cycles apart.
  - mem_read and mem_write are never both high.
- Reset mid-operation: assert rst_n=0 during ACC of a read.
  - All outputs 0 immediately (asynchronously); no resp_valid after release.
  - After release, the first grant goes to req0 when both request.
- Saturation, with CNT_W=2: 5 corrupt reads -> err_cnt goes 1,2,3,3,3.
